rx_frame_controller: RTL and testbench

Receive-side frame sequencer for the UART Rx path. It detects the start bit on the synchronised serial line, samples data bits at mid-bit using an oversampling tick, and drives the `check_parity` even-parity checker through its parity stage. It then checks the stop bit and presents each completed byte with a one-cycle valid pulse plus parity and framing status. It sits between the Rx input synchroniser and baud-tick generator upstream and the Rx FIFO / host interface downstream.

---
 rtl/rx_frame_controller.sv | 187 ++++++++++++++++++
 tb/tb_rx_frame_controller.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_controller.sv
// rx_frame_controller: UART receive frame sequencer.
// Finds the start bit and samples each bit at mid-bit using an oversampling
// tick. It strobes the external even-parity checker and checks the stop bit.
// Each finished byte is delivered with a one-cycle valid pulse plus
// parity and framing status.
module rx_frame_controller #(
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int OVERSAMPLE       = 16,
  parameter int PARITY_EN        = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        serial_in_synced,
  input  logic                        sample_tick,
  input  logic                        rx_error,
  output logic [INPUT_DATA_WIDTH-1:0] received_data,
  output logic                        is_parity_stage,
  output logic [INPUT_DATA_WIDTH-1:0] rx_data,
  output logic                        rx_valid,
  output logic                        parity_error,
  output logic                        framing_error,
  output logic                        busy
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (INPUT_DATA_WIDTH > 1) ? $clog2(INPUT_DATA_WIDTH) : 1;

  // A tick whose pre-increment count equals TICK_MID is the mid start-bit tick.
  // This is because the start-detect tick itself loads zero.
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(INPUT_DATA_WIDTH - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    PAR_WAIT,
    STOP
  } state_t;

  state_t                      state_reg, state_next;
  logic [TW-1:0]               tick_cnt_reg, tick_cnt_next;
  logic [BW-1:0]               bit_cnt_reg, bit_cnt_next;
  logic [INPUT_DATA_WIDTH-1:0] shift_reg, shift_next;
  logic                        strobe_reg, strobe_next;
  logic                        strobe_second_reg, strobe_second_next;
  logic                        par_flag_reg, par_flag_next;
  logic [INPUT_DATA_WIDTH-1:0] rx_data_reg, rx_data_next;
  logic                        rx_valid_reg, rx_valid_next;
  logic                        parity_error_reg, parity_error_next;
  logic                        framing_error_reg, framing_error_next;
  logic                        busy_reg, busy_next;

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= IDLE;
      tick_cnt_reg      <= '0;
      bit_cnt_reg       <= '0;
      shift_reg         <= '0;
      strobe_reg        <= 1'b0;
      strobe_second_reg <= 1'b0;
      par_flag_reg      <= 1'b0;
      rx_data_reg       <= '0;
      rx_valid_reg      <= 1'b0;
      parity_error_reg  <= 1'b0;
      framing_error_reg <= 1'b0;
      busy_reg          <= 1'b0;
    end else begin
      state_reg         <= state_next;
      tick_cnt_reg      <= tick_cnt_next;
      bit_cnt_reg       <= bit_cnt_next;
      shift_reg         <= shift_next;
      strobe_reg        <= strobe_next;
      strobe_second_reg <= strobe_second_next;
      par_flag_reg      <= par_flag_next;
      rx_data_reg       <= rx_data_next;
      rx_valid_reg      <= rx_valid_next;
      parity_error_reg  <= parity_error_next;
      framing_error_reg <= framing_error_next;
      busy_reg          <= busy_next;
    end
  end

  // Next-state logic: frame sequencing, bit sampling and the parity strobe.
  always_comb begin
    state_next         = state_reg;
    tick_cnt_next      = sample_tick ? (tick_cnt_reg + TICK_ONE) : tick_cnt_reg;
    bit_cnt_next       = bit_cnt_reg;
    shift_next         = shift_reg;
    strobe_next        = strobe_reg;
    strobe_second_next = strobe_second_reg;
    par_flag_next      = par_flag_reg;
    rx_data_next       = rx_data_reg;
    rx_valid_next      = 1'b0;
    parity_error_next  = parity_error_reg;
    framing_error_next = framing_error_reg;

    case (state_reg)
      IDLE: begin
        tick_cnt_next = '0;
        if (sample_tick && !serial_in_synced) begin
          state_next = START;
        end
      end

      START: begin
        if (sample_tick && (tick_cnt_reg == TICK_MID)) begin
          if (!serial_in_synced) begin
            state_next    = DATA;
            tick_cnt_next = '0;
            bit_cnt_next  = '0;
            par_flag_next = 1'b0;
          end else begin
            // Line went back high before mid start bit: a glitch, not a frame.
            state_next = IDLE;
          end
        end
      end

      DATA: begin
        if (sample_tick && (tick_cnt_reg == TICK_LAST)) begin
          tick_cnt_next = '0;
          shift_next    = {serial_in_synced, shift_reg[INPUT_DATA_WIDTH-1:1]};
          if (bit_cnt_reg == BIT_LAST) begin
            state_next = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + BIT_ONE;
          end
        end
      end

      PARITY: begin
        // The checker needs two strobe cycles: it captures on the first and
        // compares on the second. Ticks keep counting during the strobe, so
        // the stop bit stays aligned to the parity mid-bit.
        if (!strobe_reg) begin
          if (sample_tick && (tick_cnt_reg == TICK_LAST)) begin
            tick_cnt_next      = '0;
            strobe_next        = 1'b1;
            strobe_second_next = 1'b0;
          end
        end else if (!strobe_second_reg) begin
          strobe_second_next = 1'b1;
        end else begin
          strobe_next        = 1'b0;
          strobe_second_next = 1'b0;
          state_next         = PAR_WAIT;
        end
      end

      PAR_WAIT: begin
        par_flag_next = rx_error;
        state_next    = STOP;
      end

      STOP: begin
        if (sample_tick && (tick_cnt_reg == TICK_LAST)) begin
          framing_error_next = ~serial_in_synced;
          rx_data_next       = shift_reg;
          parity_error_next  = (PARITY_EN != 0) ? par_flag_reg : 1'b0;
          rx_valid_next      = 1'b1;
          state_next         = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  assign received_data   = shift_reg;
  assign is_parity_stage = strobe_reg;
  assign rx_data         = rx_data_reg;
  assign rx_valid        = rx_valid_reg;
  assign parity_error    = parity_error_reg;
  assign framing_error   = framing_error_reg;
  assign busy            = busy_reg;

endmodule

// File: tb/tb_rx_frame_controller.sv
// Directed bench for rx_frame_controller.
// One instance runs with parity enabled. A second instance has no parity bit
// and takes back-to-back frames. A small behavioural even-parity checker
// drives rx_error for the parity instance.
module tb_rx_frame_controller;

  logic       clk         = 1'b0;
  logic       reset       = 1'b1;
  logic       line0       = 1'b1;
  logic       line1       = 1'b1;
  logic       sample_tick = 1'b0;
  logic       rx_error0   = 1'b0;
  logic       rx_error1   = 1'b0;
  logic [1:0] div         = 2'd0;

  logic [7:0] recv0, data0, recv1, data1;
  logic       ps0, valid0, perr0, ferr0, busy0;
  logic       ps1, valid1, perr1, ferr1, busy1;

  int checks = 0;
  int errors = 0;

  rx_frame_controller #(.INPUT_DATA_WIDTH(8), .OVERSAMPLE(16), .PARITY_EN(1)) u_par (
    .clk(clk), .reset(reset), .serial_in_synced(line0), .sample_tick(sample_tick),
    .rx_error(rx_error0), .received_data(recv0), .is_parity_stage(ps0),
    .rx_data(data0), .rx_valid(valid0), .parity_error(perr0),
    .framing_error(ferr0), .busy(busy0)
  );

  rx_frame_controller #(.INPUT_DATA_WIDTH(8), .OVERSAMPLE(16), .PARITY_EN(0)) u_nopar (
    .clk(clk), .reset(reset), .serial_in_synced(line1), .sample_tick(sample_tick),
    .rx_error(rx_error1), .received_data(recv1), .is_parity_stage(ps1),
    .rx_data(data1), .rx_valid(valid1), .parity_error(perr1),
    .framing_error(ferr1), .busy(busy1)
  );

  always #5 clk = ~clk;

  // Oversampling tick: one clk pulse out of every four.
  always @(posedge clk) begin
    div         <= div + 2'd1;
    sample_tick <= (div == 2'd3);
  end

  // Even-parity checker model: capture on the first strobe cycle, compare on the second.
  logic pm_seen = 1'b0;
  logic pm_pbit = 1'b0;
  logic pm_dpar = 1'b0;
  always @(posedge clk) begin
    if (reset) begin
      pm_seen <= 1'b0;
    end else if (ps0) begin
      if (!pm_seen) begin
        pm_pbit <= line0;
        pm_dpar <= ^recv0;
        pm_seen <= 1'b1;
      end else begin
        rx_error0 <= pm_pbit ^ pm_dpar;
        pm_seen   <= 1'b0;
      end
    end
  end

  // Observers: count valid pulses and strobe cycles, capture delivered frames.
  int         valid_cnt0 = 0;
  int         ps_cnt0    = 0;
  int         valid_cnt1 = 0;
  int         ps_cnt1    = 0;
  logic [7:0] cap_data1 [0:3];
  logic       cap_perr1 [0:3];
  logic       cap_ferr1 [0:3];
  always @(negedge clk) begin
    if (valid0) valid_cnt0++;
    if (ps0)    ps_cnt0++;
    if (ps1)    ps_cnt1++;
    if (valid1) begin
      if (valid_cnt1 < 4) begin
        cap_data1[valid_cnt1] = data1;
        cap_perr1[valid_cnt1] = perr1;
        cap_ferr1[valid_cnt1] = ferr1;
      end
      valid_cnt1++;
    end
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait for n sample ticks, returning just after the last one has been consumed.
  task automatic hold_ticks(input int n);
    repeat (n) begin
      do @(negedge clk); while (!sample_tick);
    end
    @(negedge clk);
  endtask

  task automatic set_line(input int sel, input logic b);
    if (sel == 0) line0 = b;
    else          line1 = b;
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input bit use_par,
                            input logic pbit, input logic sbit);
    set_line(sel, 1'b0);
    hold_ticks(16);
    for (int i = 0; i < 8; i++) begin
      set_line(sel, d[i]);
      hold_ticks(16);
    end
    if (use_par) begin
      set_line(sel, pbit);
      hold_ticks(16);
    end
    set_line(sel, sbit);
    hold_ticks(16);
    set_line(sel, 1'b1);
    $display("frame sent on line %0d: data 0x%02h parity %0b stop %0b", sel, d, pbit, sbit);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_value({pfx, "_rx_valid"}, {31'd0, valid0}, 32'd0);
    check_value({pfx, "_busy"},     {31'd0, busy0},  32'd0);
    check_value({pfx, "_par_stage"},{31'd0, ps0},    32'd0);
    check_value({pfx, "_perr"},     {31'd0, perr0},  32'd0);
    check_value({pfx, "_ferr"},     {31'd0, ferr0},  32'd0);
    check_value({pfx, "_rx_data"},  {24'd0, data0},  32'd0);
    check_value({pfx, "_recv"},     {24'd0, recv0},  32'd0);
  endtask

  int v_before;
  int p_before;

  initial begin
    repeat (4) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    hold_ticks(4);

    // 0xA5, correct even parity bit 0, good stop.
    v_before = valid_cnt0; p_before = ps_cnt0;
    send_frame(0, 8'hA5, 1'b1, 1'b0, 1'b1);
    check_value("a5_valid_cnt", valid_cnt0 - v_before, 32'd1);
    check_value("a5_data", {24'd0, data0}, 32'hA5);
    check_value("a5_perr", {31'd0, perr0}, 32'd0);
    check_value("a5_ferr", {31'd0, ferr0}, 32'd0);
    check_value("a5_strobe_cycles", ps_cnt0 - p_before, 32'd2);
    hold_ticks(20);

    // 0x3C with a wrong parity bit.
    v_before = valid_cnt0; p_before = ps_cnt0;
    send_frame(0, 8'h3C, 1'b1, 1'b1, 1'b1);
    check_value("3c_valid_cnt", valid_cnt0 - v_before, 32'd1);
    check_value("3c_data", {24'd0, data0}, 32'h3C);
    check_value("3c_perr", {31'd0, perr0}, 32'd1);
    check_value("3c_ferr", {31'd0, ferr0}, 32'd0);
    check_value("3c_strobe_cycles", ps_cnt0 - p_before, 32'd2);
    hold_ticks(20);

    // Reset in the middle of the data bits of 0x55, then a clean 0x81.
    v_before = valid_cnt0;
    set_line(0, 1'b0); hold_ticks(16);
    set_line(0, 1'b1); hold_ticks(16);
    set_line(0, 1'b0); hold_ticks(16);
    set_line(0, 1'b1); hold_ticks(16);
    check_value("mid_busy", {31'd0, busy0}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    reset = 1'b0;
    $display("reset applied mid-frame");
    hold_ticks(20);
    send_frame(0, 8'h81, 1'b1, 1'b0, 1'b1);
    check_value("81_valid_cnt", valid_cnt0 - v_before, 32'd1);
    check_value("81_data", {24'd0, data0}, 32'h81);
    check_value("81_perr", {31'd0, perr0}, 32'd0);
    hold_ticks(20);

    // 0xFF with stop bit low, then a good 0x00.
    v_before = valid_cnt0;
    send_frame(0, 8'hFF, 1'b1, 1'b0, 1'b0);
    check_value("ff_valid_cnt", valid_cnt0 - v_before, 32'd1);
    check_value("ff_data", {24'd0, data0}, 32'hFF);
    check_value("ff_ferr", {31'd0, ferr0}, 32'd1);
    check_value("ff_perr", {31'd0, perr0}, 32'd0);
    hold_ticks(20);
    v_before = valid_cnt0;
    send_frame(0, 8'h00, 1'b1, 1'b0, 1'b1);
    check_value("00_valid_cnt", valid_cnt0 - v_before, 32'd1);
    check_value("00_data", {24'd0, data0}, 32'h00);
    check_value("00_ferr", {31'd0, ferr0}, 32'd0);
    check_value("00_perr", {31'd0, perr0}, 32'd0);
    hold_ticks(20);

    // Glitch: low for 3 ticks then high; back to idle by mid start bit.
    v_before = valid_cnt0;
    set_line(0, 1'b0); hold_ticks(2);
    check_value("glitch_busy_high", {31'd0, busy0}, 32'd1);
    hold_ticks(1);
    set_line(0, 1'b1); hold_ticks(6);
    check_value("glitch_busy_low", {31'd0, busy0}, 32'd0);
    hold_ticks(10);
    check_value("glitch_no_valid", valid_cnt0 - v_before, 32'd0);
    $display("glitch of 3 ticks applied");

    // No-parity instance: back-to-back 0x12 and 0x34.
    send_frame(1, 8'h12, 1'b0, 1'b0, 1'b1);
    send_frame(1, 8'h34, 1'b0, 1'b0, 1'b1);
    hold_ticks(4);
    check_value("np_valid_cnt", valid_cnt1, 32'd2);
    check_value("np_data0", {24'd0, cap_data1[0]}, 32'h12);
    check_value("np_data1", {24'd0, cap_data1[1]}, 32'h34);
    check_value("np_perr0", {31'd0, cap_perr1[0]}, 32'd0);
    check_value("np_perr1", {31'd0, cap_perr1[1]}, 32'd0);
    check_value("np_ferr1", {31'd0, cap_ferr1[1]}, 32'd0);
    check_value("np_strobe_cycles", ps_cnt1, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
